// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Direct-mapped instruction cache, one 32-bit word per line.
//               Hits are answered one cycle after acceptance from the local
//               tag/data arrays. Misses issue a level request to mem_ctrl,
//               fill the line on the response pulse and forward the word.
//               A branch flush never aborts an outstanding miss: the fill
//               still completes, only the answer to fetch is suppressed.
// Ports       : clk, rst (sync, active-high), rdy (global freeze), flush
//               fetch side : valid_from_ifetch, addr_from_ifetch ->
//                            valid_to_ifetch, inst_to_ifetch
//               memory side: valid_to_memctrl, addr_to_memctrl <-
//                            valid_from_memctrl, data_from_memctrl
//               ICACHE_STATS_EN adds hit_count / miss_count outputs.
// Revision    : 1.0  initial release
// ============================================================================
module icache #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  valid_from_ifetch,
    input  logic [ADDR_WIDTH-1:0] addr_from_ifetch,
    output logic                  valid_to_ifetch,
    output logic [31:0]           inst_to_ifetch,
    output logic                  valid_to_memctrl,
    output logic [ADDR_WIDTH-1:0] addr_to_memctrl,
    input  logic                  valid_from_memctrl,
    input  logic [31:0]           data_from_memctrl
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int c_LINES = 1 << INDEX_BITS;
    localparam int c_TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MISS  = 2'd1,   // waiting for fill, answer fetch when it arrives
        S_DRAIN = 2'd2    // waiting for fill, answer was flushed away
    } state_t;

    state_t                   r_state;
    logic [c_LINES-1:0]       r_line_valid;
    logic [c_TAG_W-1:0]       r_tag  [c_LINES];
    logic [31:0]              r_data [c_LINES];

    logic [INDEX_BITS-1:0]    w_req_index;
    logic [c_TAG_W-1:0]       w_req_tag;
    logic [INDEX_BITS-1:0]    w_fill_index;
    logic [c_TAG_W-1:0]       w_fill_tag;
    logic                     w_hit;
    logic                     w_accept;
    logic                     w_fill;
    logic [3:0]               w_unused_addr_lsb;

    assign w_req_index  = addr_from_ifetch[INDEX_BITS+1:2];
    assign w_req_tag    = addr_from_ifetch[ADDR_WIDTH-1:INDEX_BITS+2];
    // The outstanding miss address doubles as the latched fetch address.
    assign w_fill_index = addr_to_memctrl[INDEX_BITS+1:2];
    assign w_fill_tag   = addr_to_memctrl[ADDR_WIDTH-1:INDEX_BITS+2];

    assign w_hit    = r_line_valid[w_req_index] && (r_tag[w_req_index] == w_req_tag);
    // Blocking on valid_to_ifetch keeps a held request from being answered twice.
    assign w_accept = valid_from_ifetch && !valid_to_ifetch && !flush;
    assign w_fill   = (r_state != S_IDLE) && valid_from_memctrl;

    assign w_unused_addr_lsb = {addr_from_ifetch[1:0], addr_to_memctrl[1:0]};

    // Tag/data arrays carry no reset; only the valid bits need clearing.
    always_ff @(posedge clk) begin
        if (rdy && w_fill) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= data_from_memctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_line_valid     <= '0;
            valid_to_ifetch  <= 1'b0;
            inst_to_ifetch   <= '0;
            valid_to_memctrl <= 1'b0;
            addr_to_memctrl  <= '0;
        end else if (rdy) begin
            valid_to_ifetch <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_hit) begin
                            valid_to_ifetch <= 1'b1;
                            inst_to_ifetch  <= r_data[w_req_index];
                        end else begin
                            valid_to_memctrl <= 1'b1;
                            addr_to_memctrl  <= {addr_from_ifetch[ADDR_WIDTH-1:2], 2'b00};
                            r_state          <= S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    if (valid_from_memctrl) begin
                        r_line_valid[w_fill_index] <= 1'b1;
                        valid_to_memctrl           <= 1'b0;
                        r_state                    <= S_IDLE;
                        if (!flush) begin
                            valid_to_ifetch <= 1'b1;
                            inst_to_ifetch  <= data_from_memctrl;
                        end
                    end else if (flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (valid_from_memctrl) begin
                        r_line_valid[w_fill_index] <= 1'b1;
                        valid_to_memctrl           <= 1'b0;
                        r_state                    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (rdy && (r_state == S_IDLE) && w_accept) begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end else begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache
// Description : Directed self-checking bench for icache. A line-level model
//               (index -> word address/data maps plus an outstanding-miss
//               flag) predicts every output each cycle; directed scenarios
//               add hand-computed literal checks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        valid_from_ifetch = 1'b0;
    logic [31:0] addr_from_ifetch = '0;
    logic        valid_to_ifetch;
    logic [31:0] inst_to_ifetch;
    logic        valid_to_memctrl;
    logic [31:0] addr_to_memctrl;
    logic        valid_from_memctrl = 1'b0;
    logic [31:0] data_from_memctrl = '0;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .flush              (flush),
        .valid_from_ifetch  (valid_from_ifetch),
        .addr_from_ifetch   (addr_from_ifetch),
        .valid_to_ifetch    (valid_to_ifetch),
        .inst_to_ifetch     (inst_to_ifetch),
        .valid_to_memctrl   (valid_to_memctrl),
        .addr_to_memctrl    (addr_to_memctrl),
        .valid_from_memctrl (valid_from_memctrl),
        .data_from_memctrl  (data_from_memctrl)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count          (hit_count),
        .miss_count         (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- line-level reference model ----------------
    int unsigned m_line_wa   [int];
    logic [31:0] m_line_data [int];
    bit          m_live = 1'b0;
    bit          m_vti, m_vtm, m_pending, m_respond;
    logic [31:0] m_inst, m_addr;
    int unsigned m_hits, m_misses;

    task automatic model_step();
        int          idx;
        int unsigned wa;
        bit          nvti;
        if (rst) begin
            m_line_wa.delete();
            m_line_data.delete();
            m_vti = 0; m_inst = '0; m_vtm = 0; m_addr = '0;
            m_pending = 0; m_respond = 0; m_hits = 0; m_misses = 0;
            m_live = 1'b1;
        end else if (rdy) begin
            nvti = 1'b0;
            if (!m_pending) begin
                if (valid_from_ifetch && !m_vti && !flush) begin
                    wa  = addr_from_ifetch >> 2;
                    idx = int'(wa % 64);
                    if (m_line_wa.exists(idx) && m_line_wa[idx] == wa) begin
                        nvti   = 1'b1;
                        m_inst = m_line_data[idx];
                        m_hits++;
                    end else begin
                        m_pending = 1'b1;
                        m_respond = 1'b1;
                        m_vtm     = 1'b1;
                        m_addr    = wa << 2;
                        m_misses++;
                    end
                end
            end else if (valid_from_memctrl) begin
                wa  = m_addr >> 2;
                idx = int'(wa % 64);
                m_line_wa[idx]   = wa;
                m_line_data[idx] = data_from_memctrl;
                m_pending = 1'b0;
                m_vtm     = 1'b0;
                if (m_respond && !flush) begin
                    nvti   = 1'b1;
                    m_inst = data_from_memctrl;
                end
            end else if (flush) begin
                m_respond = 1'b0;
            end
            m_vti = nvti;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Single compare process, sampling on the falling edge.
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("mdl_valid_to_ifetch", valid_to_ifetch, m_vti);
            if (m_vti) chk("mdl_inst_to_ifetch", inst_to_ifetch, m_inst);
            chk("mdl_valid_to_memctrl", valid_to_memctrl, m_vtm);
            if (m_vtm) chk("mdl_addr_to_memctrl", addr_to_memctrl, m_addr);
`ifdef ICACHE_STATS_EN
            chk("mdl_hit_count", hit_count, m_hits);
            chk("mdl_miss_count", miss_count, m_misses);
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus helpers ----------------
    // All helpers start and end on a falling edge.
    task automatic fetch_hit(input logic [31:0] a, input logic [31:0] d);
        valid_from_ifetch = 1'b1;
        addr_from_ifetch  = a;
        @(negedge clk);
        chk("hit_valid", valid_to_ifetch, 1);
        chk("hit_inst", inst_to_ifetch, d);
        chk("hit_no_mem_req", valid_to_memctrl, 0);
        valid_from_ifetch = 1'b0;
        @(negedge clk);
    endtask

    task automatic fetch_miss(input logic [31:0] a, input int delay, input logic [31:0] d);
        logic [31:0] aligned;
        aligned = {a[31:2], 2'b00};
        valid_from_ifetch = 1'b1;
        addr_from_ifetch  = a;
        @(negedge clk);
        chk("miss_req", valid_to_memctrl, 1);
        chk("miss_addr", addr_to_memctrl, aligned);
        chk("miss_no_resp", valid_to_ifetch, 0);
        repeat (delay - 1) begin
            @(negedge clk);
            chk("miss_req_held", valid_to_memctrl, 1);
            chk("miss_addr_held", addr_to_memctrl, aligned);
        end
        valid_from_memctrl = 1'b1;
        data_from_memctrl  = d;
        @(negedge clk);
        chk("fill_valid", valid_to_ifetch, 1);
        chk("fill_inst", inst_to_ifetch, d);
        chk("fill_req_drop", valid_to_memctrl, 0);
        valid_from_memctrl = 1'b0;
        valid_from_ifetch  = 1'b0;
        @(negedge clk);
    endtask

    int pulses;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid_to_ifetch", valid_to_ifetch, 0);
        chk("rst_inst", inst_to_ifetch, 0);
        chk("rst_valid_to_memctrl", valid_to_memctrl, 0);
        chk("rst_addr", addr_to_memctrl, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1. cold miss, 5-cycle memory latency
        fetch_miss(32'h104, 5, 32'h00A00093);
        // 2. same address hits
        fetch_hit(32'h104, 32'h00A00093);
        // 3. low address bits ignored; same-index conflict evicts
        fetch_hit(32'h106, 32'h00A00093);
        fetch_miss(32'h204, 2, 32'h11111111);
        fetch_hit(32'h204, 32'h11111111);
        fetch_miss(32'h104, 3, 32'h00A00093);

        // held request: answers at most every second cycle
        pulses = 0;
        valid_from_ifetch = 1'b1;
        addr_from_ifetch  = 32'h104;
        repeat (4) begin
            @(negedge clk);
            if (valid_to_ifetch) pulses++;
        end
        chk("b2b_pulses", pulses, 2);
        valid_from_ifetch = 1'b0;
        @(negedge clk);

        // flush in IDLE drops the coincident request
        valid_from_ifetch = 1'b1;
        addr_from_ifetch  = 32'h104;
        flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_drop", valid_to_ifetch, 0);
        flush = 1'b0;
        @(negedge clk);
        chk("after_flush_hit", valid_to_ifetch, 1);
        valid_from_ifetch = 1'b0;
        @(negedge clk);

        // 4. flush two cycles into a miss: fill happens, no answer
        valid_from_ifetch = 1'b1;
        addr_from_ifetch  = 32'h300;
        @(negedge clk);
        chk("t4_req", valid_to_memctrl, 1);
        @(negedge clk);
        flush = 1'b1;
        valid_from_ifetch = 1'b0;
        @(negedge clk);
        chk("t4_req_kept", valid_to_memctrl, 1);
        flush = 1'b1;                       // repeated flush in DRAIN
        @(negedge clk);
        flush = 1'b0;
        valid_from_memctrl = 1'b1;
        data_from_memctrl  = 32'h12345678;
        @(negedge clk);
        chk("t4_no_resp", valid_to_ifetch, 0);
        chk("t4_req_drop", valid_to_memctrl, 0);
        valid_from_memctrl = 1'b0;
        @(negedge clk);
        chk("t4_no_late_resp", valid_to_ifetch, 0);
        fetch_hit(32'h300, 32'h12345678);

        // 5. flush coincident with the fill pulse
        valid_from_ifetch = 1'b1;
        addr_from_ifetch  = 32'h400;
        @(negedge clk);
        @(negedge clk);
        valid_from_memctrl = 1'b1;
        data_from_memctrl  = 32'hDEADBEEF;
        flush = 1'b1;
        valid_from_ifetch = 1'b0;
        @(negedge clk);
        chk("t5_no_resp", valid_to_ifetch, 0);
        chk("t5_req_drop", valid_to_memctrl, 0);
        valid_from_memctrl = 1'b0;
        flush = 1'b0;
        fetch_hit(32'h400, 32'hDEADBEEF);

        // 6. rdy low for three cycles in the middle of a miss
        valid_from_ifetch = 1'b1;
        addr_from_ifetch  = 32'h500;
        @(negedge clk);
        rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_req_frozen", valid_to_memctrl, 1);
            chk("t6_addr_frozen", addr_to_memctrl, 32'h500);
            chk("t6_no_resp", valid_to_ifetch, 0);
        end
        rdy = 1'b1;
        @(negedge clk);
        valid_from_memctrl = 1'b1;
        data_from_memctrl  = 32'hCAFEF00D;
        @(negedge clk);
        chk("t6_resp", valid_to_ifetch, 1);
        chk("t6_inst", inst_to_ifetch, 32'hCAFEF00D);
        valid_from_memctrl = 1'b0;
        valid_from_ifetch  = 1'b0;
        @(negedge clk);

        // 7. reset mid-miss, then the old hit address misses again
        valid_from_ifetch = 1'b1;
        addr_from_ifetch  = 32'h600;
        @(negedge clk);
        chk("t7_req", valid_to_memctrl, 1);
        rst = 1'b1;
        valid_from_ifetch = 1'b0;
        @(negedge clk);
        chk("t7_rst_req_drop", valid_to_memctrl, 0);
        chk("t7_rst_no_resp", valid_to_ifetch, 0);
        rst = 1'b0;
        @(negedge clk);
        fetch_miss(32'h104, 3, 32'h00A00093);
`ifdef ICACHE_STATS_EN
        chk("t7_hit_count", hit_count, 0);
        chk("t7_miss_count", miss_count, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
